clkgen_mc: RTL and testbench

Multi-channel, synthesisable clock-waveform generator for the async-FIFO bench. It runs from one reference clock and produces NUM_CH independent square waves, each with a programmable half-period, start phase and bounded cycle-to-cycle jitter. Channels start and stop glitch-free through a valid/ready configuration port. It supersedes free-running per-domain clock models when the bench needs run-time control of frequency ratios, jitter and start/stop.

---
 rtl/clkgen_mc.sv | 206 ++++++++++++++++++++
 tb/tb_clkgen_mc.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/clkgen_mc.sv
// Multi-channel square-wave generator: per-channel half-period, start phase and
// LFSR-driven bounded jitter, with glitch-free start/stop through a valid/ready port.
module clkgen_mc #(
    parameter int          NUM_CH    = 2,
    parameter int          DIV_W     = 16,
    parameter int          JIT_W     = 4,
    parameter logic [15:0] LFSR_SEED = 16'hACE1,
    localparam int         CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic              cfg_en,
    input  logic [DIV_W-1:0]  cfg_half,
    input  logic [JIT_W-1:0]  cfg_jit,
    input  logic [DIV_W-1:0]  cfg_phase,
    output logic [NUM_CH-1:0] clk_out,
    output logic [NUM_CH-1:0] tick,
    output logic [NUM_CH-1:0] active
);

    // state   | meaning
    // S_IDLE  | stopped, clk_out low
    // S_PHASE | counting the start delay, clk_out low
    // S_RUN   | toggling every effective half-period
    // S_DRAIN | last high half-period after a stop, then low and idle
    typedef enum logic [1:0] {S_IDLE, S_PHASE, S_RUN, S_DRAIN} state_t;

    localparam logic [DIV_W-1:0]        D_ONE    = {{(DIV_W-1){1'b0}}, 1'b1};
    localparam logic signed [DIV_W+1:0] S_ONE    = {{(DIV_W+1){1'b0}}, 1'b1};
    localparam logic signed [DIV_W+1:0] S_MAX    = {2'b00, {DIV_W{1'b1}}};
    localparam logic [15:0]             SEED_EFF = (LFSR_SEED == 16'h0000) ? 16'h0001 : LFSR_SEED;

    state_t            r_state   [NUM_CH];
    state_t            w_state   [NUM_CH];
    logic [DIV_W-1:0]  r_cnt     [NUM_CH];
    logic [DIV_W-1:0]  w_cnt     [NUM_CH];
    logic [DIV_W-1:0]  r_half    [NUM_CH];
    logic [DIV_W-1:0]  w_half    [NUM_CH];
    logic [DIV_W-1:0]  r_sh_half [NUM_CH];
    logic [DIV_W-1:0]  w_sh_half [NUM_CH];
    logic [JIT_W-1:0]  r_jit     [NUM_CH];
    logic [JIT_W-1:0]  w_jit     [NUM_CH];
    logic [JIT_W-1:0]  r_sh_jit  [NUM_CH];
    logic [JIT_W-1:0]  w_sh_jit  [NUM_CH];
    logic [DIV_W-1:0]  w_reload  [NUM_CH];
    logic [NUM_CH-1:0] r_sh_en, w_sh_en, r_pend, w_pend, r_clk, w_clk, r_tick, w_tick;
    logic [NUM_CH-1:0] w_hit, w_apply;
    logic [15:0]       r_lfsr, w_lfsr;

    // Reload value Heff-1 with Heff = clamp(max(half,1) + sat(r, +-J), 1, 2^DIV_W-1).
    function automatic logic [DIV_W-1:0] f_reload(
        input logic [DIV_W-1:0] half,
        input logic [JIT_W-1:0] jb,
        input logic [JIT_W:0]   rr
    );
        logic signed [JIT_W+1:0] r_s;
        logic signed [JIT_W+1:0] j_max;
        logic signed [JIT_W+1:0] j_s;
        logic signed [DIV_W+1:0] sum;
        logic [DIV_W-1:0]        h;
        logic [DIV_W-1:0]        heff;
        h     = (half == '0) ? D_ONE : half;
        r_s   = $signed({rr[JIT_W], rr});
        j_max = $signed({2'b00, jb});
        if (r_s > j_max)       j_s = j_max;
        else if (r_s < -j_max) j_s = -j_max;
        else                   j_s = r_s;
        sum = $signed({2'b00, h}) + $signed({{(DIV_W-JIT_W){j_s[JIT_W+1]}}, j_s});
        if (sum < S_ONE)      heff = D_ONE;
        else if (sum > S_MAX) heff = {DIV_W{1'b1}};
        else                  heff = sum[DIV_W-1:0];
        return heff - D_ONE;
    endfunction

    // Out-of-range channel numbers are always ready and never hit a channel.
    always_comb begin
        cfg_ready = 1'b1;
        for (int i = 0; i < NUM_CH; i++) begin
            if (cfg_ch == CH_W'(i)) cfg_ready = !r_pend[i];
        end
    end

    always_comb begin
        w_hit   = '0;
        w_apply = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            w_hit[i]   = cfg_valid && cfg_ready && (cfg_ch == CH_W'(i));
            w_apply[i] = r_pend[i] && (r_state[i] == S_RUN) && (r_cnt[i] == '0);
            w_reload[i] = w_apply[i] ? f_reload(r_sh_half[i], r_sh_jit[i], r_lfsr[JIT_W:0])
                                     : f_reload(r_half[i], r_jit[i], r_lfsr[JIT_W:0]);
        end
    end

    always_comb begin
        w_lfsr  = {1'b0, r_lfsr[15:1]} ^ (r_lfsr[0] ? 16'hB400 : 16'h0000);
        w_sh_en = r_sh_en;
        w_pend  = r_pend;
        w_clk   = r_clk;
        w_tick  = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            w_state[i]   = r_state[i];
            w_cnt[i]     = r_cnt[i];
            w_half[i]    = r_half[i];
            w_jit[i]     = r_jit[i];
            w_sh_half[i] = r_sh_half[i];
            w_sh_jit[i]  = r_sh_jit[i];
            case (r_state[i])
                S_IDLE: begin
                    if (w_hit[i] && cfg_en) begin
                        w_half[i]  = cfg_half;
                        w_jit[i]   = cfg_jit;
                        w_cnt[i]   = cfg_phase;
                        w_state[i] = S_PHASE;
                    end
                end
                S_PHASE: begin
                    if (w_hit[i] && !cfg_en) begin
                        w_state[i] = S_IDLE;
                    end else if (r_cnt[i] == '0) begin
                        w_clk[i]   = 1'b1;
                        w_tick[i]  = 1'b1;
                        w_cnt[i]   = w_reload[i];
                        w_state[i] = S_RUN;
                    end else begin
                        w_cnt[i] = r_cnt[i] - D_ONE;
                    end
                end
                S_RUN: begin
                    if (r_cnt[i] == '0) begin
                        w_clk[i]  = !r_clk[i];
                        w_tick[i] = 1'b1;
                        w_cnt[i]  = w_reload[i];
                        if (r_pend[i]) begin
                            w_half[i] = r_sh_half[i];
                            w_jit[i]  = r_sh_jit[i];
                            w_pend[i] = 1'b0;
                            // A stop that leaves the output high must finish that high phase.
                            if (!r_sh_en[i]) w_state[i] = r_clk[i] ? S_IDLE : S_DRAIN;
                        end
                    end else begin
                        w_cnt[i] = r_cnt[i] - D_ONE;
                    end
                    if (w_hit[i]) begin
                        w_sh_half[i] = cfg_half;
                        w_sh_jit[i]  = cfg_jit;
                        w_sh_en[i]   = cfg_en;
                        w_pend[i]    = 1'b1;
                    end
                end
                S_DRAIN: begin
                    if (r_cnt[i] == '0) begin
                        w_clk[i]   = 1'b0;
                        w_tick[i]  = 1'b1;
                        w_state[i] = S_IDLE;
                    end else begin
                        w_cnt[i] = r_cnt[i] - D_ONE;
                    end
                end
                default: w_state[i] = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_lfsr  <= SEED_EFF;
            r_sh_en <= '0;
            r_pend  <= '0;
            r_clk   <= '0;
            r_tick  <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                r_state[i]   <= S_IDLE;
                r_cnt[i]     <= '0;
                r_half[i]    <= '0;
                r_jit[i]     <= '0;
                r_sh_half[i] <= '0;
                r_sh_jit[i]  <= '0;
            end
        end else begin
            r_lfsr  <= w_lfsr;
            r_sh_en <= w_sh_en;
            r_pend  <= w_pend;
            r_clk   <= w_clk;
            r_tick  <= w_tick;
            for (int i = 0; i < NUM_CH; i++) begin
                r_state[i]   <= w_state[i];
                r_cnt[i]     <= w_cnt[i];
                r_half[i]    <= w_half[i];
                r_jit[i]     <= w_jit[i];
                r_sh_half[i] <= w_sh_half[i];
                r_sh_jit[i]  <= w_sh_jit[i];
            end
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_CH; i++) active[i] = (r_state[i] != S_IDLE);
    end

    assign clk_out = r_clk;
    assign tick    = r_tick;

endmodule

// File: tb/tb_clkgen_mc.sv
// Directed bench for clkgen_mc: expected toggle edges are queued when a channel is
// configured and popped by a negedge monitor whenever the DUT ticks.
`timescale 1ns/1ps
module tb_clkgen_mc;
    localparam int          NUM_CH = 2;
    localparam int          DIV_W  = 16;
    localparam int          JIT_W  = 4;
    localparam logic [15:0] SEED   = 16'hACE1;

    logic              clk = 1'b0;
    logic              rst, cfg_valid, cfg_ready, cfg_ch, cfg_en;
    logic [DIV_W-1:0]  cfg_half, cfg_phase;
    logic [JIT_W-1:0]  cfg_jit;
    logic [NUM_CH-1:0] clk_out, tick, active;

    typedef struct { int t; bit lvl; } ev_t;
    ev_t q0[$];
    ev_t q1[$];

    int cyc = 0, total = 0, bad = 0, t_rst = 0, last0 = 0;
    bit jit_on = 1'b0, have_prev = 1'b0;
    logic [NUM_CH-1:0] prev_clk = '0;

    clkgen_mc #(.NUM_CH(NUM_CH), .DIV_W(DIV_W), .JIT_W(JIT_W), .LFSR_SEED(SEED)) dut (
        .clk(clk), .rst(rst), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .cfg_ch(cfg_ch), .cfg_en(cfg_en), .cfg_half(cfg_half), .cfg_jit(cfg_jit),
        .cfg_phase(cfg_phase), .clk_out(clk_out), .tick(tick), .active(active)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic push(input int ch, input int t, input bit lvl);
        ev_t e;
        e.t = t;
        e.lvl = lvl;
        if (ch == 0) q0.push_back(e);
        else q1.push_back(e);
    endtask

    task automatic plan(input int ch, input int t0, input bit lvl0, input int half, input int t_end);
        int t = t0;
        bit l = lvl0;
        while (t < t_end) begin
            push(ch, t, l);
            t += half;
            l = !l;
        end
    endtask

    function automatic logic [15:0] lstep(input logic [15:0] v);
        return v[0] ? ((v >> 1) ^ 16'hB400) : (v >> 1);
    endfunction

    function automatic int jitter_of(input logic [15:0] v, input int jb);
        int r = int'(v[4:0]);
        if (r > 15) r -= 32;
        if (r > jb) return jb;
        if (r < -jb) return -jb;
        return r;
    endfunction

    // LFSR value used at edge t is the seed advanced (t-1-t_rst) times.
    task automatic plan_jit(input int ch, input int t0, input int half, input int jb,
                            input int n, output int t_stop);
        logic [15:0] v = SEED;
        int at = t_rst + 1;
        int t = t0;
        bit l = 1'b1;
        int h;
        t_stop = t0 + 1;
        for (int k = 0; k < n; k++) begin
            push(ch, t, l);
            while (at < t) begin
                v = lstep(v);
                at++;
            end
            h = half + jitter_of(v, jb);
            if (h < 1) h = 1;
            t_stop = t + 1;
            t += h;
            l = !l;
        end
    endtask

    task automatic wait_until(input int t);
        while (cyc < t) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        repeat (n) @(posedge clk);
        #1;
        t_rst = cyc;
        rst = 1'b0;
    endtask

    task automatic cfg(input int ch, input bit en, input int half, input int jb, input int ph,
                       output int e, output int stalls);
        bit rdy;
        int n = 0;
        cfg_valid = 1'b1;
        cfg_ch    = ch[0];
        cfg_en    = en;
        cfg_half  = half[DIV_W-1:0];
        cfg_jit   = jb[JIT_W-1:0];
        cfg_phase = ph[DIV_W-1:0];
        stalls = 0;
        #1;
        do begin
            rdy = cfg_ready;
            if (!rdy) stalls++;
            @(posedge clk);
            #1;
            n++;
        end while (!rdy && n < 50);
        chk("cfg_accepted", rdy, 1);
        e = cyc;
        cfg_valid = 1'b0;
    endtask

    task automatic end_check(input string tag);
        chk({tag, "_q0_left"}, q0.size(), 0);
        chk({tag, "_q1_left"}, q1.size(), 0);
        chk({tag, "_clk_out"}, clk_out, 0);
        chk({tag, "_tick"}, tick, 0);
        chk({tag, "_active"}, active, 0);
        q0.delete();
        q1.delete();
    endtask

    always @(negedge clk) begin
        for (int c = 0; c < NUM_CH; c++) begin : mon
            ev_t e;
            bit got;
            if (tick[c] === 1'b1) begin
                got = (c == 0) ? (q0.size() > 0) : (q1.size() > 0);
                chk($sformatf("ch%0d_tick_expected", c), got, 1);
                if (got) begin
                    if (c == 0) e = q0.pop_front();
                    else e = q1.pop_front();
                    chk($sformatf("ch%0d_tick_edge", c), cyc, e.t);
                    chk($sformatf("ch%0d_level", c), clk_out[c], e.lvl);
                end
                if (c == 0 && jit_on) begin
                    if (have_prev) chk("jit_half_range", (cyc - last0 >= 1) && (cyc - last0 <= 7), 1);
                    have_prev = 1'b1;
                    last0 = cyc;
                end
            end
            if (clk_out[c] !== prev_clk[c] && cyc != t_rst)
                chk($sformatf("ch%0d_change_has_tick", c), tick[c], 1);
            prev_clk[c] = clk_out[c];
        end
    end

    initial begin
        int e, e1, s, a, b, r, ts;
        rst = 1'b1; cfg_valid = 1'b0; cfg_ch = 1'b0; cfg_en = 1'b0;
        cfg_half = '0; cfg_jit = '0; cfg_phase = '0;
        do_reset(3);
        end_check("reset");
        chk("reset_ready", cfg_ready, 1);

        // basic start: half=3, P=0
        cfg(0, 1, 3, 0, 0, e, s);
        plan(0, e + 1, 1'b1, 3, e + 40);
        wait_until(e + 39);
        do_reset(1);
        end_check("t1");

        // two channels, ch1 delayed by its phase
        cfg(0, 1, 2, 0, 0, e, s);
        plan(0, e + 1, 1'b1, 2, e + 210);
        cfg(1, 1, 5, 0, 4, e1, s);
        chk("t2_ch1_accept", e1, e + 1);
        plan(1, e1 + 5, 1'b1, 5, e + 210);
        wait_until(e + 209);
        do_reset(1);
        end_check("t2");

        // shadow update mid-high, second request stalled by pending
        cfg(0, 1, 4, 0, 0, e, s);
        r = e + 1;
        push(0, r, 1'b1);
        push(0, r + 4, 1'b0);
        wait_until(r);
        cfg(0, 1, 2, 0, 0, a, s);
        chk("t3_accept1", a, r + 1);
        cfg(0, 1, 3, 0, 0, b, s);
        chk("t3_stall_cycles", s, 3);
        chk("t3_accept2", b, r + 5);
        plan(0, r + 6, 1'b1, 3, r + 40);
        wait_until(r + 39);
        do_reset(1);
        end_check("t3");

        // stop while high: ends at the falling edge
        cfg(0, 1, 6, 0, 0, e, s);
        r = e + 1;
        push(0, r, 1'b1);
        push(0, r + 6, 1'b0);
        wait_until(r);
        cfg(0, 0, 6, 0, 0, a, s);
        chk("t4_accept", a, r + 1);
        wait_until(r + 5);
        chk("t4_active_before", active[0], 1);
        chk("t4_high_before", clk_out[0], 1);
        wait_until(r + 6);
        chk("t4_active_after", active[0], 0);
        chk("t4_low_after", clk_out[0], 0);
        wait_until(r + 20);
        chk("t4_q0_left", q0.size(), 0);

        // stop while low: one full drain high phase, then idle
        cfg(0, 1, 6, 0, 0, e, s);
        r = e + 1;
        push(0, r, 1'b1);
        push(0, r + 6, 1'b0);
        push(0, r + 12, 1'b1);
        push(0, r + 18, 1'b0);
        wait_until(r + 7);
        cfg(0, 0, 6, 0, 0, a, s);
        chk("t4b_accept", a, r + 8);
        wait_until(r + 17);
        chk("t4b_active_drain", active[0], 1);
        chk("t4b_high_drain", clk_out[0], 1);
        wait_until(r + 18);
        chk("t4b_active_after", active[0], 0);
        chk("t4b_low_after", clk_out[0], 0);
        wait_until(r + 30);
        chk("t4b_q0_left", q0.size(), 0);

        // jitter J=3 on ch0 against the LFSR model, J=0 control on ch1
        do_reset(1);
        have_prev = 1'b0;
        jit_on = 1'b1;
        cfg(0, 1, 4, 3, 0, e, s);
        plan_jit(0, e + 1, 4, 3, 1000, ts);
        cfg(1, 1, 4, 0, 0, e1, s);
        plan(1, e1 + 1, 1'b1, 4, ts);
        wait_until(ts - 1);
        do_reset(1);
        jit_on = 1'b0;
        end_check("t5");

        // reset with ch0 draining and ch1 still in its phase delay
        cfg(0, 1, 6, 0, 0, e, s);
        r = e + 1;
        push(0, r, 1'b1);
        push(0, r + 6, 1'b0);
        push(0, r + 12, 1'b1);
        cfg(1, 1, 2, 0, 50, e1, s);
        wait_until(r + 7);
        cfg(0, 0, 6, 0, 0, a, s);
        chk("t6_accept_stop", a, r + 8);
        wait_until(r + 14);
        chk("t6_active_pre", active, 2'b11);
        chk("t6_clk_pre", clk_out, 2'b01);
        do_reset(1);
        end_check("t6");
        cfg_ch = 1'b0;
        #1;
        chk("t6_ready_ch0", cfg_ready, 1);
        cfg_ch = 1'b1;
        #1;
        chk("t6_ready_ch1", cfg_ready, 1);

        // LFSR restarts from the seed after reset
        have_prev = 1'b0;
        jit_on = 1'b1;
        cfg(0, 1, 4, 3, 2, e, s);
        plan_jit(0, e + 3, 4, 3, 40, ts);
        wait_until(ts - 1);
        do_reset(1);
        jit_on = 1'b0;
        end_check("t6b");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
